ifu_fetch: RTL and testbench

- Instruction fetch stage directly downstream of the PC register.
- Captures PC on a `Pvalid` pulse and issues one AXI4-Lite read to instruction memory.
- Delivers the instruction word to decode via a valid/ready handshake.
- Single outstanding fetch; multi-cycle core, so the next PC arrives only after write-back.

---
 rtl/ifu_fetch_pkg.sv | 19 +
 rtl/ifu_perf_cnt.sv | 42 ++++
 rtl/ifu_fetch.sv | 152 +++++++++++++++
 tb/tb_ifu_fetch.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg: shared definitions for the instruction fetch stage.
//   ifu_state_e   - fetch FSM states (IDLE, ADDR, DATA, OUT)
//   AXI_RESP_OKAY - AXI read response code for a good transfer
//   RESET_PC      - boot address, shared with the PC stage
//   NOP_INST      - canonical NOP (addi x0,x0,0), reserved for flush handling
package ifu_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    OUT  = 2'd3
  } ifu_state_e;

  localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;
  localparam logic [31:0] RESET_PC      = 32'h8000_0000;
  localparam logic [31:0] NOP_INST      = 32'h0000_0013;

endpackage

// File: rtl/ifu_perf_cnt.sv
// ifu_perf_cnt: pair of 64-bit saturating event counters for the fetch stage.
//   clk, rst    - core clock, asynchronous active-high reset (clears both)
//   inc_fetch   - one completed fetch handed to decode this cycle
//   inc_stall   - fetch unit waiting on the AXI slave this cycle
//   perf_fetch  - completed fetch count
//   perf_stall  - bus wait cycle count
module ifu_perf_cnt
  import ifu_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_fetch,
  input  logic        inc_stall,
  output logic [63:0] perf_fetch,
  output logic [63:0] perf_stall
);

  logic [63:0] fetch_cnt_q, fetch_cnt_d;
  logic [63:0] stall_cnt_q, stall_cnt_d;

  // Counters stop at all-ones rather than wrapping.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (inc_fetch && (fetch_cnt_q != '1)) fetch_cnt_d = fetch_cnt_q + 64'd1;
    if (inc_stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 64'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_fetch = fetch_cnt_q;
  assign perf_stall = stall_cnt_q;

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch stage. Captures PC on a Pvalid pulse, issues a
// single AXI4-Lite read and hands the instruction word to decode.
//   clk, rst        - core clock, asynchronous active-high reset
//   Pvalid/PC/Pready- fetch request from the PC stage (Pready = idle)
//   ar*/r*          - AXI4-Lite read channels to instruction memory
//   Inst/InstPC/Ierr/Ivalid/Iready - result handshake to decode
// Optional: define IFU_PERF_CNT_EN to add perf_fetch/perf_stall counters.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Pvalid,
  input  logic [ADDR_WIDTH-1:0] PC,
  output logic                  Pready,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [DATA_WIDTH-1:0] Inst,
  output logic [ADDR_WIDTH-1:0] InstPC,
  output logic                  Ierr,
  output logic                  Ivalid,
  input  logic                  Iready
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [63:0]           perf_fetch,
  output logic [63:0]           perf_stall
`endif
);

  ifu_state_e            state_q,   state_d;
  logic [ADDR_WIDTH-1:0] araddr_q,  araddr_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q,  rready_d;
  logic [DATA_WIDTH-1:0] inst_q,    inst_d;
  logic [ADDR_WIDTH-1:0] inst_pc_q, inst_pc_d;
  logic                  ierr_q,    ierr_d;
  logic                  ivalid_q,  ivalid_d;

  always_comb begin
    state_d   = state_q;
    araddr_d  = araddr_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    ierr_d    = ierr_q;
    ivalid_d  = ivalid_q;
    unique case (state_q)
      IDLE: begin
        if (Pvalid) begin
          inst_pc_d = PC;
          if (PC[1:0] == 2'b00) begin
            araddr_d  = PC;
            arvalid_d = 1'b1;
            state_d   = ADDR;
          end else begin
            // Misaligned PC faults straight to decode without touching the bus.
            inst_d   = '0;
            ierr_d   = 1'b1;
            ivalid_d = 1'b1;
            state_d  = OUT;
          end
        end
      end
      ADDR: begin
        if (arvalid_q && arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (rvalid && rready_q) begin
          inst_d   = rdata;
          ierr_d   = (rresp != AXI_RESP_OKAY);
          rready_d = 1'b0;
          ivalid_d = 1'b1;
          state_d  = OUT;
        end
      end
      OUT: begin
        if (ivalid_q && Iready) begin
          ivalid_d = 1'b0;
          ierr_d   = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
      ierr_q    <= 1'b0;
      ivalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      araddr_q  <= araddr_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      ierr_q    <= ierr_d;
      ivalid_q  <= ivalid_d;
    end
  end

  assign Pready  = (state_q == IDLE);
  assign araddr  = araddr_q;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;
  assign Inst    = inst_q;
  assign InstPC  = inst_pc_q;
  assign Ierr    = ierr_q;
  assign Ivalid  = ivalid_q;

  // Upstream must wait for Pready; a request while busy is dropped.
  pvalid_while_busy_a: assert property (@(posedge clk) disable iff (rst)
    !(Pvalid && (state_q != IDLE)));

`ifdef IFU_PERF_CNT_EN
  logic perf_inc_fetch;
  logic perf_inc_stall;

  assign perf_inc_fetch = ivalid_q && Iready;
  assign perf_inc_stall = (state_q == ADDR) || (state_q == DATA);

  ifu_perf_cnt u_perf_cnt (
    .clk        (clk),
    .rst        (rst),
    .inc_fetch  (perf_inc_fetch),
    .inc_stall  (perf_inc_stall),
    .perf_fetch (perf_fetch),
    .perf_stall (perf_stall)
  );
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed scoreboard bench for ifu_fetch with a small
// AXI4-Lite slave model (programmable address/data wait cycles) and a decode
// model (programmable Iready delay).
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Pvalid = 1'b0;
  logic [31:0] PC = '0;
  logic        Pready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] Inst;
  logic [31:0] InstPC;
  logic        Ierr;
  logic        Ivalid;
  logic        Iready;
`ifdef IFU_PERF_CNT_EN
  logic [63:0] perf_fetch;
  logic [63:0] perf_stall;
`endif

  ifu_fetch #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .Pvalid  (Pvalid),
    .PC      (PC),
    .Pready  (Pready),
    .araddr  (araddr),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rready  (rready),
    .Inst    (Inst),
    .InstPC  (InstPC),
    .Ierr    (Ierr),
    .Ivalid  (Ivalid),
    .Iready  (Iready)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetch (perf_fetch),
    .perf_stall (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // ---------------- AXI slave and decode models ----------------
  int          ar_wait = 0, r_wait = 0, ird_wait = 0;
  int          ar_cnt, r_cnt, ird_cnt;
  logic        have_addr;
  logic [31:0] mem_rdata = '0;
  logic [1:0]  mem_rresp = 2'b00;

  assign arready = !have_addr && (ar_cnt == ar_wait);
  assign rvalid  = have_addr && (r_cnt == r_wait);
  assign rdata   = mem_rdata;
  assign rresp   = mem_rresp;
  assign Iready  = (ird_cnt >= ird_wait);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ar_cnt    <= 0;
      r_cnt     <= 0;
      have_addr <= 1'b0;
      ird_cnt   <= 0;
    end else begin
      if (arvalid && arready) begin
        have_addr <= 1'b1;
        ar_cnt    <= 0;
        r_cnt     <= 0;
      end else if (arvalid) begin
        ar_cnt <= ar_cnt + 1;
      end
      if (have_addr) begin
        if (rvalid && rready) have_addr <= 1'b0;
        else if (rready)      r_cnt <= r_cnt + 1;
      end
      if (Ivalid && Iready) ird_cnt <= 0;
      else if (Ivalid)      ird_cnt <= ird_cnt + 1;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        ierr;
    int          issue;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] cur_pc = '0;
  logic        expect_no_ar = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // ---------------- monitor ----------------
  logic        ivalid_prev = 1'b0;
  logic        idle_next = 1'b0;
  logic        ar_pend_prev = 1'b0;
  logic [31:0] ar_pend_addr = '0;

  always @(negedge clk) begin
    if (rst) begin
      ivalid_prev  = 1'b0;
      idle_next    = 1'b0;
      ar_pend_prev = 1'b0;
    end else begin
      if (ar_pend_prev) begin
        chk("arvalid_hold", {63'd0, arvalid}, 64'd1);
        chk("araddr_hold", {32'd0, araddr}, {32'd0, ar_pend_addr});
      end
      ar_pend_prev = arvalid && !arready;
      ar_pend_addr = araddr;
      if (arvalid) chk("araddr", {32'd0, araddr}, {32'd0, cur_pc});
      if (expect_no_ar) chk("no_arvalid", {63'd0, arvalid}, 64'd0);
      if (idle_next) begin
        chk("pready_after_hs", {63'd0, Pready}, 64'd1);
        chk("ivalid_after_hs", {63'd0, Ivalid}, 64'd0);
        idle_next = 1'b0;
      end
      if (Ivalid) begin
        if (sb.size() == 0) begin
          chk("unexpected_ivalid", {63'd0, Ivalid}, 64'd0);
        end else begin
          exp_t e;
          e = sb[0];
          chk("inst", {32'd0, Inst}, {32'd0, e.inst});
          chk("inst_pc", {32'd0, InstPC}, {32'd0, e.pc});
          chk("ierr", {63'd0, Ierr}, {63'd0, e.ierr});
          chk("pready_busy", {63'd0, Pready}, 64'd0);
          if (!ivalid_prev)
            chk("latency", 64'(cyc - e.issue), 64'(e.lat));
          if (Iready) begin
            void'(sb.pop_front());
            expect_no_ar = 1'b0;
            idle_next    = 1'b1;
          end
        end
      end
      ivalid_prev = Ivalid;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle(input string name);
    @(negedge clk);
    for (int i = 0; i < 200 && !(Pready && sb.size() == 0); i++) @(negedge clk);
    if (!(Pready && sb.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout got pready=%0d pending=%0d want idle", name, Pready, sb.size());
    end
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] rd, input logic [1:0] resp,
                       input int aw, input int rw, input int iw,
                       input logic [31:0] e_inst, input logic e_ierr, input int lat,
                       input logic push);
    exp_t e;
    wait_idle("issue");
    ar_wait   = aw;
    r_wait    = rw;
    ird_wait  = iw;
    mem_rdata = rd;
    mem_rresp = resp;
    cur_pc    = pc;
    expect_no_ar = (pc[1:0] != 2'b00);
    if (push) begin
      e.inst  = e_inst;
      e.pc    = pc;
      e.ierr  = e_ierr;
      e.issue = cyc;
      e.lat   = lat;
      sb.push_back(e);
    end
    PC     = pc;
    Pvalid = 1'b1;
    @(negedge clk);
    Pvalid = 1'b0;
  endtask

  initial begin
    // Reset state, sampled while rst is still asserted.
    @(negedge clk);
    chk("rst_pready", {63'd0, Pready}, 64'd1);
    chk("rst_arvalid", {63'd0, arvalid}, 64'd0);
    chk("rst_rready", {63'd0, rready}, 64'd0);
    chk("rst_ivalid", {63'd0, Ivalid}, 64'd0);
    chk("rst_ierr", {63'd0, Ierr}, 64'd0);
    chk("rst_inst", {32'd0, Inst}, 64'd0);
    chk("rst_instpc", {32'd0, InstPC}, 64'd0);
    chk("rst_araddr", {32'd0, araddr}, 64'd0);
    rst = 1'b0;

    //     pc            rdata         resp   aw rw iw  exp inst      ierr lat push
    issue(32'h8000_0000, 32'h0000_0297, 2'b00, 0, 0, 0, 32'h0000_0297, 1'b0, 3,  1'b1);
    issue(32'h8000_0010, 32'h00a0_0093, 2'b00, 4, 3, 0, 32'h00a0_0093, 1'b0, 10, 1'b1);
    issue(32'h8000_0014, 32'h0010_0113, 2'b00, 0, 0, 5, 32'h0010_0113, 1'b0, 3,  1'b1);
    issue(32'h8000_0018, 32'hdead_beef, 2'b10, 0, 0, 0, 32'hdead_beef, 1'b1, 3,  1'b1);
    issue(32'h8000_0002, 32'h1234_5678, 2'b00, 0, 0, 0, 32'h0000_0000, 1'b1, 1,  1'b1);

    // Reset while waiting for read data; the read is abandoned.
    issue(32'h8000_0008, 32'h0bad_0bad, 2'b00, 0, 5, 0, 32'h0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 50 && !rready; i++) @(negedge clk);
    chk("reach_data", {63'd0, rready}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_rready", {63'd0, rready}, 64'd0);
    chk("mid_rst_ivalid", {63'd0, Ivalid}, 64'd0);
    chk("mid_rst_pready", {63'd0, Pready}, 64'd1);
    chk("mid_rst_arvalid", {63'd0, arvalid}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    issue(32'h8000_0004, 32'h0000_0513, 2'b00, 0, 0, 0, 32'h0000_0513, 1'b0, 3, 1'b1);
    wait_idle("drain");

`ifdef IFU_PERF_CNT_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    issue(32'h8000_0020, 32'h0000_0001, 2'b00, 1, 1, 0, 32'h0000_0001, 1'b0, 5, 1'b1);
    issue(32'h8000_0024, 32'h0000_0002, 2'b00, 1, 1, 0, 32'h0000_0002, 1'b0, 5, 1'b1);
    issue(32'h8000_0028, 32'h0000_0003, 2'b00, 1, 1, 0, 32'h0000_0003, 1'b0, 5, 1'b1);
    wait_idle("perf_drain");
    chk("perf_fetch", perf_fetch, 64'd3);
    chk("perf_stall", perf_stall, 64'd12);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
